// File: rtl/ebus_ctl_pkg.sv
// Shared types and constants for the EBUS master controller.
// Function codes follow the KL10 EBUS encoding.
package ebus_ctl_pkg;

    localparam int EBUS_CS_W   = 7;
    localparam int EBUS_FUNC_W = 3;

    localparam logic [EBUS_FUNC_W-1:0] EBUS_FUNC_CONO   = 3'd0;
    localparam logic [EBUS_FUNC_W-1:0] EBUS_FUNC_CONI   = 3'd1;
    localparam logic [EBUS_FUNC_W-1:0] EBUS_FUNC_DATAO  = 3'd2;
    localparam logic [EBUS_FUNC_W-1:0] EBUS_FUNC_DATAI  = 3'd3;
    localparam logic [EBUS_FUNC_W-1:0] EBUS_FUNC_PISERV = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DEMAND,
        RELEASE
    } tEBUSctlState;

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int owner, input int n);
        return (owner + 1 >= n) ? 0 : owner + 1;
    endfunction

endpackage

// File: rtl/ebus_rr_arb.sv
// Combinational round-robin pick: the first set request at or after ptr,
// wrapping to index 0. Returns a one-hot grant, the winner index and a valid flag.
module ebus_rr_arb
    import ebus_ctl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && req[j] && (j >= int'(ptr))) begin
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                valid  = 1'b1;
            end
        end
        // wrap-around pass below the pointer
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && req[j] && (j < int'(ptr))) begin
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ebus_master_ctl.sv
// EBUS master: arbitrates EBOX/DTE ownership and sequences one EBUS cycle per grant.
// Also flags cycles where more than one module drives the EBUS data lines.
//
//   state   | meaning
//   IDLE    | bus free, pick next requester round-robin
//   SETUP   | CS/func driven, counting down before DEMAND
//   DEMAND  | DEMAND asserted, waiting for TRANSFER or timeout
//   RELEASE | TRANSFER seen, hold CS/func until slave drops TRANSFER
module ebus_master_ctl
    import ebus_ctl_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int NDRV        = 13,
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          CROBAR,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*EBUS_CS_W-1:0]     reqCs,
    input  logic [NREQ*EBUS_FUNC_W-1:0]   reqFunc,
    input  logic                          ebusXfer,
    input  logic [NDRV-1:0]               drvVec,
    output logic [NREQ-1:0]               grant,
    output logic [EBUS_CS_W-1:0]          ebusCs,
    output logic [EBUS_FUNC_W-1:0]        ebusFunc,
    output logic                          ebusDemand,
    output logic [NREQ-1:0]               done,
    output logic [NREQ-1:0]               timeout,
    output logic                          busy,
    output logic                          conflict
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       SETUP_LOAD = 4'(SETUP_CYC - 1);

    tEBUSctlState state, state_nxt;

    logic [IDX_W-1:0]       ptr, ptr_nxt, ptr_after;
    logic [IDX_W-1:0]       owner, owner_nxt;
    logic [3:0]             setup_cnt, setup_nxt;
    logic [TMO_W-1:0]       tmo_cnt, tmo_nxt;
    logic [NREQ-1:0]        grant_nxt, done_nxt, timeout_nxt;
    logic [EBUS_CS_W-1:0]   cs_nxt, cs_sel;
    logic [EBUS_FUNC_W-1:0] func_nxt, func_sel;
    logic                   demand_nxt;
    logic                   conflict_nxt;

    logic [NREQ-1:0]        arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_valid;

    ebus_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        cs_sel   = '0;
        func_sel = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (arb_gnt[j]) begin
                cs_sel   = reqCs[j*EBUS_CS_W +: EBUS_CS_W];
                func_sel = reqFunc[j*EBUS_FUNC_W +: EBUS_FUNC_W];
            end
        end
    end

    assign ptr_after = IDX_W'(rr_next(int'(owner), NREQ));

    // x & (x-1) is non-zero exactly when two or more bits are set
    assign conflict_nxt = |(drvVec & (drvVec - NDRV'(1)));

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        setup_nxt   = setup_cnt;
        tmo_nxt     = tmo_cnt;
        grant_nxt   = grant;
        cs_nxt      = ebusCs;
        func_nxt    = ebusFunc;
        demand_nxt  = ebusDemand;
        done_nxt    = '0;
        timeout_nxt = '0;

        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_nxt = arb_gnt;
                    owner_nxt = arb_idx;
                    cs_nxt    = cs_sel;
                    func_nxt  = func_sel;
                    setup_nxt = SETUP_LOAD;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt == 4'd0) begin
                    demand_nxt = 1'b1;
                    tmo_nxt    = '0;
                    state_nxt  = DEMAND;
                end else begin
                    setup_nxt = setup_cnt - 4'd1;
                end
            end
            DEMAND: begin
                // TRANSFER takes priority over a coincident timeout
                if (ebusXfer) begin
                    done_nxt   = grant;
                    demand_nxt = 1'b0;
                    state_nxt  = RELEASE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_nxt = grant;
                    demand_nxt  = 1'b0;
                    grant_nxt   = '0;
                    cs_nxt      = '0;
                    func_nxt    = '0;
                    ptr_nxt     = ptr_after;
                    state_nxt   = IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            RELEASE: begin
                if (!ebusXfer) begin
                    grant_nxt = '0;
                    cs_nxt    = '0;
                    func_nxt  = '0;
                    ptr_nxt   = ptr_after;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            setup_cnt  <= '0;
            tmo_cnt    <= '0;
            grant      <= '0;
            ebusCs     <= '0;
            ebusFunc   <= '0;
            ebusDemand <= 1'b0;
            done       <= '0;
            timeout    <= '0;
            conflict   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            owner      <= owner_nxt;
            setup_cnt  <= setup_nxt;
            tmo_cnt    <= tmo_nxt;
            grant      <= grant_nxt;
            ebusCs     <= cs_nxt;
            ebusFunc   <= func_nxt;
            ebusDemand <= demand_nxt;
            done       <= done_nxt;
            timeout    <= timeout_nxt;
            conflict   <= conflict_nxt;
        end
    end

endmodule

// File: tb/tb_ebus_master_ctl.sv
// Bench for ebus_master_ctl: directed EBUS cycles with a queue of expected
// grants/completions checked by an independent negedge monitor.
module tb_ebus_master_ctl;

    logic        clk = 1'b0;
    logic        CROBAR;
    logic [1:0]  req;
    logic [13:0] reqCs;
    logic [5:0]  reqFunc;
    logic        ebusXfer;
    logic [12:0] drvVec;
    logic [1:0]  grant;
    logic [6:0]  ebusCs;
    logic [2:0]  ebusFunc;
    logic        ebusDemand;
    logic [1:0]  done;
    logic [1:0]  timeout;
    logic        busy;
    logic        conflict;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] grant;
        logic [6:0] cs;
        logic [2:0] func;
        logic [1:0] done;
        logic [1:0] tmo;
        int         lat;
        bit         abort;
    } exp_t;

    exp_t q[$];

    ebus_master_ctl dut (
        .clk        (clk),
        .CROBAR     (CROBAR),
        .req        (req),
        .reqCs      (reqCs),
        .reqFunc    (reqFunc),
        .ebusXfer   (ebusXfer),
        .drvVec     (drvVec),
        .grant      (grant),
        .ebusCs     (ebusCs),
        .ebusFunc   (ebusFunc),
        .ebusDemand (ebusDemand),
        .done       (done),
        .timeout    (timeout),
        .busy       (busy),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [6:0] cs, input logic [2:0] f,
                            input logic [1:0] d, input logic [1:0] t, input int lat, input bit ab);
        exp_t e;
        e.grant = g; e.cs = cs; e.func = f; e.done = d; e.tmo = t; e.lat = lat; e.abort = ab;
        q.push_back(e);
    endtask

    // sel: 0 grant set, 1 demand high, 2 demand low, 3 pulse on done/timeout
    task automatic wait_for(input int sel, input string nm);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(posedge clk); #1;
            case (sel)
                0:       hit = (grant != 2'b00);
                1:       hit = ebusDemand;
                2:       hit = !ebusDemand;
                default: hit = (done != 2'b00) || (timeout != 2'b00);
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: event not seen within 300 cycles", nm);
        end
    endtask

    // Slave samples DEMAND at entry E (caller is at E+#1); TRANSFER is sampled at edge E+n.
    task automatic run_xfer(input int n, input logic [1:0] own, input logic [6:0] cs_exp);
        repeat (n - 1) @(posedge clk);
        #1 ebusXfer = 1'b1;
        wait_for(2, "demand_low");
        @(posedge clk); #1;
        chk("hold_grant", grant, own);
        chk("hold_cs", ebusCs, cs_exp);
        chk("hold_busy", busy, 1'b1);
        ebusXfer = 1'b0;
        @(posedge clk); #1;
        chk("release_grant", grant, 2'b00);
        chk("release_cs", ebusCs, 7'd0);
        chk("release_busy", busy, 1'b0);
    endtask

    logic [1:0] prev_grant = 2'b00;
    logic       prev_dem   = 1'b0;
    int         g_cyc      = 0;
    int         d_cyc      = 0;

    always @(negedge clk) begin
        exp_t e;
        if (grant != 2'b00 && prev_grant == 2'b00) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %0h with nothing queued", grant);
            end else begin
                e = q[0];
                chk("grant", grant, e.grant);
                chk("grant_cs", ebusCs, e.cs);
                chk("grant_func", ebusFunc, e.func);
                g_cyc = cyc;
                if (e.abort) q.delete(0);
            end
        end
        if (ebusDemand && !prev_dem) begin
            chk("setup_lat", cyc - g_cyc, 2);
            d_cyc = cyc;
        end
        if (done != 2'b00 || timeout != 2'b00) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done %0h timeout %0h with nothing queued", done, timeout);
            end else begin
                e = q[0];
                q.delete(0);
                chk("done", done, e.done);
                chk("timeout", timeout, e.tmo);
                chk("demand_lat", cyc - d_cyc, e.lat);
                chk("pulse_demand", ebusDemand, 1'b0);
                chk("pulse_cs", ebusCs, (e.done != 2'b00) ? e.cs : 7'd0);
            end
        end
        prev_grant = grant;
        prev_dem   = ebusDemand;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        CROBAR   = 1'b1;
        req      = 2'b00;
        reqCs    = {7'o34, 7'o12};
        reqFunc  = {3'b011, 3'b010};
        ebusXfer = 1'b0;
        drvVec   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_demand", ebusDemand, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_conflict", conflict, 1'b0);
        chk("rst_cs", ebusCs, 7'd0);
        chk("rst_func", ebusFunc, 3'd0);
        chk("rst_done", done, 2'b00);
        chk("rst_timeout", timeout, 2'b00);
        CROBAR = 1'b0;

        // driver conflict monitor
        drvVec = 13'h0088;
        @(posedge clk); #1;
        chk("conflict_3_7", conflict, 1'b1);
        drvVec = 13'h0000;
        @(posedge clk); #1;
        chk("conflict_clear", conflict, 1'b0);
        drvVec = 13'h0020;
        @(posedge clk); #1;
        chk("conflict_single", conflict, 1'b0);
        drvVec = 13'h1fff;
        @(posedge clk); #1;
        chk("conflict_all", conflict, 1'b1);
        drvVec = 13'h1000;
        @(posedge clk); #1;
        chk("conflict_msb", conflict, 1'b0);
        drvVec = 13'h0000;
        @(posedge clk); #1;
        chk("conflict_zero", conflict, 1'b0);

        // single EBOX request, TRANSFER sampled 3 cycles into DEMAND
        push_exp(2'b01, 7'o12, 3'b010, 2'b01, 2'b00, 3, 1'b0);
        req = 2'b01;
        @(posedge clk); #1;
        chk("grant_lat", grant, 2'b01);
        chk("busy_on", busy, 1'b1);
        req = 2'b00;
        wait_for(1, "demand");
        run_xfer(3, 2'b01, 7'o12);

        // simultaneous requests from reset: EBOX, DTE, EBOX
        CROBAR = 1'b1;
        @(posedge clk); #1;
        CROBAR = 1'b0;
        push_exp(2'b01, 7'o12, 3'b010, 2'b01, 2'b00, 2, 1'b0);
        push_exp(2'b10, 7'o34, 3'b011, 2'b10, 2'b00, 2, 1'b0);
        push_exp(2'b01, 7'o12, 3'b010, 2'b01, 2'b00, 2, 1'b0);
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wait_for(0, "grant");
            if (i == 2) req = 2'b00;
            wait_for(1, "demand");
            if (i == 1) run_xfer(2, 2'b10, 7'o34);
            else        run_xfer(2, 2'b01, 7'o12);
        end

        // DTE times out with no TRANSFER
        push_exp(2'b10, 7'o34, 3'b011, 2'b00, 2'b10, 64, 1'b0);
        req = 2'b10;
        wait_for(0, "grant");
        req = 2'b00;
        wait_for(1, "demand");
        wait_for(3, "pulse");
        chk("tmo_grant", grant, 2'b00);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_func", ebusFunc, 3'd0);

        // TRANSFER on the same edge the timeout count is reached
        push_exp(2'b01, 7'o12, 3'b010, 2'b01, 2'b00, 64, 1'b0);
        req = 2'b01;
        wait_for(0, "grant");
        req = 2'b00;
        wait_for(1, "demand");
        run_xfer(64, 2'b01, 7'o12);

        // reset during DEMAND; pointer is at DTE beforehand
        push_exp(2'b10, 7'o34, 3'b011, 2'b00, 2'b00, 0, 1'b1);
        push_exp(2'b01, 7'o12, 3'b010, 2'b01, 2'b00, 2, 1'b0);
        req = 2'b11;
        wait_for(0, "grant");
        wait_for(1, "demand");
        @(posedge clk); #1;
        CROBAR = 1'b1;
        @(posedge clk); #1;
        chk("crobar_demand", ebusDemand, 1'b0);
        chk("crobar_grant", grant, 2'b00);
        chk("crobar_cs", ebusCs, 7'd0);
        chk("crobar_func", ebusFunc, 3'd0);
        chk("crobar_busy", busy, 1'b0);
        CROBAR = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_grant", grant, 2'b01);
        req = 2'b00;
        wait_for(1, "demand");
        run_xfer(2, 2'b01, 7'o12);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebus_master_ctl.md
# ebus_master_ctl

EBUS master controller: arbitrates EBUS ownership between the EBOX (APR side) and the DTE, then sequences one KL10-style EBUS cycle per grant: controller select and function setup, DEMAND, slave TRANSFER handshake, release, with a timeout. It also watches the per-module `EBUSdriver.driving` flags that feed the top-level EBUS data mux. It flags any cycle where more than one module drives. It sits in `top` beside the EBUS data mux.

## Interface

Parameters:
- `NREQ`, 2: number of requesters. Index 0 is EBOX, index 1 is DTE.
- `NDRV`, 13: number of EBUS data-driver flags monitored.
- `SETUP_CYC`, 2: cycles CS/func are held before DEMAND. Legal range is 1..15.
- `TIMEOUT_CYC`, 64: cycles in DEMAND without TRANSFER before timeout. Must be at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `CROBAR`  in  1  reset, synchronous and active-high.
- `req`  in  NREQ  per-requester transfer request, level.
- `reqCs`  in  NREQ×7  per-requester controller select, [0:6].
- `reqFunc`  in  NREQ×3  per-requester EBUS function, [0:2].
- `ebusXfer`  in  1  slave TRANSFER.
- `drvVec`  in  NDRV  `EBUSdriver.driving` flags from every module.
- `grant`  out  NREQ  one-hot owner; all zero when idle.
- `ebusCs`  out  7  registered CS of the owner.
- `ebusFunc`  out  3  registered function of the owner.
- `ebusDemand`  out  1  EBUS DEMAND.
- `done`  out  NREQ  one-cycle pulse to the owner when TRANSFER is seen.
- `timeout`  out  NREQ  one-cycle pulse to the owner on timeout.
- `busy`  out  1  high in every state except IDLE.
- `conflict`  out  1  registered; high the cycle after `drvVec` has more than one bit set.

## Operation

- States: IDLE → SETUP → DEMAND → RELEASE → IDLE.
- **IDLE**
  - If any `req` is set, a round-robin pick starts at pointer `ptr`.
  - Register the winner into `grant`, and its `reqCs` and `reqFunc` into `ebusCs` and `ebusFunc`.
  - Load the setup counter with `SETUP_CYC-1` and go to SETUP.
- **SETUP**
  - Hold CS/func and decrement the counter.
  - When the counter is 0, assert `ebusDemand`, clear the timeout counter and go to DEMAND.
- **DEMAND**
  - Increment the timeout counter.
  - If `ebusXfer` is high: pulse `done[owner]`, drop `ebusDemand` and go to RELEASE.
  - Otherwise, when the counter reaches `TIMEOUT_CYC-1`: pulse `timeout[owner]`, drop `ebusDemand`, and go directly to IDLE, clearing grant, CS and func.
  - If `ebusXfer` and the timeout happen in the same cycle, `ebusXfer` wins.
- **RELEASE**
  - Keep grant, CS and func until `ebusXfer` is low.
  - Then clear grant, CS and func, set `ptr` to owner+1 (mod NREQ), and go to IDLE.
  - The timeout path also updates `ptr` the same way.
- Once granted, a `req` is sampled only in IDLE. Dropping it mid-cycle does not abort the transfer.
- `conflict` is evaluated every cycle, independent of the FSM. It equals the popcount of `drvVec` being greater than 1, registered.
- On reset, all outputs go to 0, `ptr` goes to 0, both counters clear, and the state goes to IDLE. This applies mid-transfer: `ebusDemand` drops the cycle after `CROBAR` is sampled.

## Timing

- From `req` rising in IDLE to `grant`/CS/func valid: 1 cycle.
- `ebusDemand` rises `SETUP_CYC` cycles after grant.
- `done` is a pulse in the cycle after `ebusXfer` is sampled high in DEMAND.
- Minimum back-to-back: after RELEASE exits, the next grant comes 1 cycle later, because IDLE always lasts at least 1 cycle.
- With `TIMEOUT_CYC`=64, the `timeout` pulse comes exactly 64 cycles after DEMAND entry when there is no TRANSFER.
- The timeout counter width is `$clog2(TIMEOUT_CYC)`. It saturates and never wraps.
- The setup counter is 4 bits.

## Structure

- `ebus_ctl_pkg`:
  - state enum `tEBUSctlState` (IDLE, SETUP, DEMAND, RELEASE);
  - width constants `EBUS_CS_W`=7 and `EBUS_FUNC_W`=3;
  - EBUS function code constants (CONO, CONI, DATAO, DATAI, PI-serve).
- One sub-module: `ebus_rr_arb`, a combinational round-robin pick from `req` and `ptr` that returns a one-hot value plus the winner index. The FSM, counters and conflict register live in `ebus_master_ctl`.

## Test plan

- **Single request:** `req`=01, CS=7'o12, func=3'b010, slave asserts `ebusXfer` 3 cycles into DEMAND → `grant`=01 at +1, DEMAND at +3, `done`=01 pulse, CS and func hold through RELEASE, then all clear.
- **Simultaneous requests:** `req`=11 from reset → EBOX granted first. When its cycle completes with the DTE still requesting, the DTE is granted next and `ptr` alternates.
- **Timeout:** `ebusXfer` never asserted → `timeout`=owner pulse exactly 64 cycles after DEMAND, no `done`, return to IDLE.
- **Tie:** `ebusXfer` rises in the same cycle the timeout count would be reached → `done` pulses, `timeout` stays 0.
- **Reset mid-cycle:** assert `CROBAR` during DEMAND → the next cycle has `ebusDemand`, `grant`, CS, func and `busy` all 0, and the next grant goes to requester 0.
- **Conflict:** `drvVec` with bits 3 and 7 set for 1 cycle → `conflict` high for exactly the following cycle; a single bit or all-zero `drvVec` keeps it 0.
